// File: rtl/pipe_stall_ctrl.sv
// Purpose : central stall/bubble scheduler for the 5-stage pipeline (load-use, branch-operand,
//           HI/LO wait, mult/div busy window, SYSCALL/ERET drain before PC redirect).
// Latency : hazard controls are combinational in the same cycle; drain redirect after DRAIN_CYCLES.
// Backpressure: stalls freeze PC and IF/ID and flush ID/EX; hazard > BranchBubble > run.
// Ports   : Clk/Reset (async, active-high); ID operand fields and use flags, branch/hilo/cp0Op
//           qualifiers; EX/MEM destination and load/write flags; md_start from EX.
//           Outputs hazard, BranchBubble, cp0Bubble (mutually exclusive IF/ID freezes),
//           idex_flush, pc_write, cp0_redirect (1-cycle pulse), md_busy.
module pipe_stall_ctrl #(
  parameter int MD_CYCLES    = 32,  // legal 2..63
  parameter int DRAIN_CYCLES = 3    // legal 1..7
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_use_rs,
  input  logic       id_use_rt,
  input  logic       id_is_branch,
  input  logic       id_hilo_rd,
  input  logic [2:0] id_cp0Op,
  input  logic       ex_MemRead,
  input  logic       ex_RegWrite,
  input  logic [4:0] ex_rd,
  input  logic       mem_MemRead,
  input  logic [4:0] mem_rd,
  input  logic       md_start,
  output logic       hazard,
  output logic       BranchBubble,
  output logic       cp0Bubble,
  output logic       idex_flush,
  output logic       pc_write,
  output logic       cp0_redirect,
  output logic       md_busy
);

  localparam logic [2:0] OP_SYSCALL = 3'b100;
  localparam logic [2:0] OP_ERET    = 3'b011;

  typedef enum logic [1:0] {RUN, MD_BUSY, CP0_DRAIN} state_t;

  state_t     state, state_nx;
  logic [5:0] md_cnt, md_cnt_nx;
  logic [2:0] dr_cnt, dr_cnt_nx;
  // md_act marks an in-flight mult/div independently of the FSM state, so the
  // busy window stays exact while the FSM is parked in CP0_DRAIN.
  logic       md_act, md_act_nx;

  logic mex, mmem, load_use, br_haz, hilo_haz, cp0_op;

  assign mex  = (ex_rd != 5'd0) &&
                ((id_use_rs && id_rs == ex_rd) || (id_use_rt && id_rt == ex_rd));
  assign mmem = (mem_rd != 5'd0) &&
                ((id_use_rs && id_rs == mem_rd) || (id_use_rt && id_rt == mem_rd));

  assign load_use = ex_MemRead && mex;
  assign br_haz   = id_is_branch && ((ex_RegWrite && mex) || (mem_MemRead && mmem));
  assign hilo_haz = md_act && id_hilo_rd;
  assign cp0_op   = (id_cp0Op == OP_SYSCALL) || (id_cp0Op == OP_ERET);

  // Mult/div counter runs in the background in every state; md_start always
  // (re)loads it, including a restart while already busy.
  always_comb begin
    md_cnt_nx = md_cnt;
    md_act_nx = md_act;
    if (md_start) begin
      md_cnt_nx = 6'(MD_CYCLES - 1);
      md_act_nx = 1'b1;
    end else if (md_act) begin
      if (md_cnt == 6'd0) md_act_nx = 1'b0;
      else                md_cnt_nx = md_cnt - 6'd1;
    end
  end

  always_comb begin
    state_nx     = state;
    dr_cnt_nx    = dr_cnt;
    hazard       = 1'b0;
    BranchBubble = 1'b0;
    cp0Bubble    = 1'b0;
    idex_flush   = 1'b0;
    pc_write     = 1'b0;
    cp0_redirect = 1'b0;
    md_busy      = md_act;

    case (state)
      RUN, MD_BUSY: begin
        if (load_use || hilo_haz) begin
          hazard     = 1'b1;
          idex_flush = 1'b1;
        end else if (br_haz) begin
          BranchBubble = 1'b1;
          idex_flush   = 1'b1;
        end else begin
          pc_write = 1'b1;
        end
        if (cp0_op && !load_use && !hilo_haz && !br_haz) begin
          state_nx  = CP0_DRAIN;
          dr_cnt_nx = 3'(DRAIN_CYCLES - 1);
        end else begin
          state_nx = md_act_nx ? MD_BUSY : RUN;
        end
      end
      CP0_DRAIN: begin
        // Hazard sources are masked here; any new cp0Op is ignored (no nesting).
        cp0Bubble  = 1'b1;
        idex_flush = 1'b1;
        if (dr_cnt == 3'd0) begin
          pc_write     = 1'b1;
          cp0_redirect = 1'b1;
          state_nx     = md_act_nx ? MD_BUSY : RUN;
        end else begin
          dr_cnt_nx = dr_cnt - 3'd1;
        end
      end
      default: state_nx = RUN;
    endcase

    // Outputs drop the moment Reset rises, not at the next edge.
    if (Reset) begin
      hazard       = 1'b0;
      BranchBubble = 1'b0;
      cp0Bubble    = 1'b0;
      idex_flush   = 1'b0;
      pc_write     = 1'b0;
      cp0_redirect = 1'b0;
      md_busy      = 1'b0;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state  <= RUN;
      md_cnt <= 6'd0;
      dr_cnt <= 3'd0;
      md_act <= 1'b0;
    end else begin
      state  <= state_nx;
      md_cnt <= md_cnt_nx;
      dr_cnt <= dr_cnt_nx;
      md_act <= md_act_nx;
    end
  end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
module tb_pipe_stall_ctrl;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [4:0] id_rs, id_rt, ex_rd, mem_rd;
  logic       id_use_rs, id_use_rt, id_is_branch, id_hilo_rd;
  logic [2:0] id_cp0Op;
  logic       ex_MemRead, ex_RegWrite, mem_MemRead, md_start;
  logic       hazard, BranchBubble, cp0Bubble, idex_flush, pc_write, cp0_redirect, md_busy;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  pipe_stall_ctrl #(.MD_CYCLES(32), .DRAIN_CYCLES(3)) dut (
    .Clk(Clk), .Reset(Reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_is_branch(id_is_branch), .id_hilo_rd(id_hilo_rd), .id_cp0Op(id_cp0Op),
    .ex_MemRead(ex_MemRead), .ex_RegWrite(ex_RegWrite), .ex_rd(ex_rd),
    .mem_MemRead(mem_MemRead), .mem_rd(mem_rd), .md_start(md_start),
    .hazard(hazard), .BranchBubble(BranchBubble), .cp0Bubble(cp0Bubble),
    .idex_flush(idex_flush), .pc_write(pc_write), .cp0_redirect(cp0_redirect),
    .md_busy(md_busy)
  );

  // {hazard, BranchBubble, cp0Bubble, idex_flush, pc_write, cp0_redirect, md_busy}
  wire [6:0] outs = {hazard, BranchBubble, cp0Bubble, idex_flush, pc_write, cp0_redirect, md_busy};

  localparam logic [6:0] O_RUN    = 7'b0000100;
  localparam logic [6:0] O_HAZ    = 7'b1001000;
  localparam logic [6:0] O_BB     = 7'b0101000;
  localparam logic [6:0] O_DRAIN  = 7'b0011000;
  localparam logic [6:0] O_REDIR  = 7'b0011110;
  localparam logic [6:0] O_IDLE   = 7'b0000000;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic clear_in();
    id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0; id_is_branch = 0;
    id_hilo_rd = 0; id_cp0Op = 3'b000; ex_MemRead = 0; ex_RegWrite = 0;
    ex_rd = 0; mem_MemRead = 0; mem_rd = 0; md_start = 0;
  endtask

  // Sets rs-use load-use inputs: EX load to r5, ID reads r5.
  task automatic set_load_use();
    ex_MemRead = 1; ex_rd = 5; id_rs = 5; id_use_rs = 1;
  endtask

  initial begin : main
    logic [2:0] ops [2];
    int busy_cnt, haz_cnt, redir_cnt;
    ops[0] = 3'b100;
    ops[1] = 3'b011;

    clear_in();
    Reset = 1;
    #2;
    chk("reset_outs", 32'(outs), 32'(O_IDLE));
    cyc(); cyc();
    Reset = 0;
    cyc();
    chk("after_reset_run", 32'(outs), 32'(O_RUN));

    // Load-use: exactly one stall cycle.
    set_load_use(); #1;
    chk("load_use", 32'(outs), 32'(O_HAZ));
    cyc(); ex_MemRead = 0; #1;
    chk("load_use_release", 32'(outs), 32'(O_RUN));

    // Register 0 never matches.
    cyc(); clear_in(); ex_MemRead = 1; id_use_rs = 1; #1;
    chk("reg0_no_stall", 32'(outs), 32'(O_RUN));

    // Branch operand produced by ALU op in EX.
    cyc(); clear_in(); id_is_branch = 1; ex_RegWrite = 1; ex_rd = 8; id_rt = 8; id_use_rt = 1; #1;
    chk("br_ex_bubble", 32'(outs), 32'(O_BB));
    cyc(); ex_RegWrite = 0; #1;
    chk("br_ex_release", 32'(outs), 32'(O_RUN));
    // Branch operand still a load in MEM.
    mem_MemRead = 1; mem_rd = 8; #1;
    chk("br_mem_bubble", 32'(outs), 32'(O_BB));
    // Load-use into a branch raises hazard only.
    cyc(); mem_MemRead = 0; ex_MemRead = 1; ex_RegWrite = 1; ex_rd = 8; #1;
    chk("lu_branch_hazard_only", 32'(outs), 32'(O_HAZ));
    cyc(); ex_MemRead = 0; #1;
    chk("lu_branch_then_bb", 32'(outs), 32'(O_BB));

    // SYSCALL / ERET drain.
    foreach (ops[k]) begin
      cyc(); clear_in(); id_cp0Op = ops[k]; #1;
      chk("cp0_trigger_cycle", 32'(outs), 32'(O_RUN));
      cyc(); #1;  // op still presented: must be ignored during the drain
      chk("drain_1", 32'(outs), 32'(O_DRAIN));
      cyc(); id_cp0Op = 3'b000; set_load_use(); #1;
      chk("drain_2_masked", 32'(outs), 32'(O_DRAIN));
      cyc(); clear_in(); #1;
      chk("drain_3_redirect", 32'(outs), 32'(O_REDIR));
      cyc(); #1;
      chk("drain_back_run", 32'(outs), 32'(O_RUN));
    end
    // Other encodings ignored.
    cyc(); id_cp0Op = 3'b001;
    cyc(); id_cp0Op = 3'b000; #1;
    chk("op001_ignored", 32'(outs), 32'(O_RUN));

    // SYSCALL with load-use: hazard wins, drain starts one cycle later.
    cyc(); id_cp0Op = 3'b100; set_load_use(); #1;
    chk("sys_lu_hazard", 32'(outs), 32'(O_HAZ));
    cyc(); ex_MemRead = 0; #1;
    chk("sys_lu_trigger", 32'(outs), 32'(O_RUN));
    cyc(); clear_in(); #1;
    chk("sys_lu_drain", 32'(outs), 32'(O_DRAIN));
    cyc(); cyc(); cyc(); #1;
    chk("sys_lu_done", 32'(outs), 32'(O_RUN));

    // Mult/div: busy exactly 32 cycles; HI/LO read from cycle 10 waits until it ends.
    md_start = 1; #1;
    chk("md_start_cycle", 32'(md_busy), 32'(0));
    busy_cnt = 0; haz_cnt = 0;
    for (int c = 1; c <= 40; c++) begin
      cyc(); md_start = 0;
      if (c == 10) id_hilo_rd = 1;
      #1;
      if (md_busy) busy_cnt++;
      if (hazard) haz_cnt++;
      if (c == 33) chk("hilo_release_pcw", 32'(pc_write), 32'(1));
      if (c == 32) chk("hilo_last_stall", 32'(hazard), 32'(1));
    end
    chk("md_busy_len", 32'(busy_cnt), 32'(32));
    chk("hilo_stall_len", 32'(haz_cnt), 32'(23));
    id_hilo_rd = 0;

    // Restart on cycle 5 extends busy through cycle 37.
    cyc(); md_start = 1;
    busy_cnt = 0;
    for (int c = 1; c <= 45; c++) begin
      cyc(); md_start = (c == 5); #1;
      if (md_busy) busy_cnt++;
      if (c == 37) chk("md_restart_last", 32'(md_busy), 32'(1));
      if (c == 38) chk("md_restart_off", 32'(md_busy), 32'(0));
    end
    chk("md_restart_len", 32'(busy_cnt), 32'(37));
    md_start = 0;

    // SYSCALL during mult/div: drain runs, busy window unchanged, back to MD_BUSY.
    cyc(); md_start = 1;
    busy_cnt = 0;
    for (int c = 1; c <= 40; c++) begin
      cyc(); md_start = 0; id_cp0Op = (c == 4) ? 3'b100 : 3'b000; #1;
      if (md_busy) busy_cnt++;
      if (c == 5) chk("md_drain_1", 32'(outs), 32'(O_DRAIN | 7'b1));
      if (c == 7) chk("md_drain_redir", 32'(outs), 32'(O_REDIR | 7'b1));
      if (c == 8) chk("md_after_drain", 32'(outs), 32'(O_RUN | 7'b1));
      if (c == 33) chk("md_after_drain_end", 32'(outs), 32'(O_RUN));
    end
    chk("md_drain_busy_len", 32'(busy_cnt), 32'(32));

    // Async reset in the middle of a drain.
    cyc(); clear_in(); id_cp0Op = 3'b100;
    cyc(); id_cp0Op = 3'b000; #1;
    chk("rst_drain_entered", 32'(outs), 32'(O_DRAIN));
    #2; Reset = 1; #1;
    chk("rst_async_outs", 32'(outs), 32'(O_IDLE));
    redir_cnt = 0;
    cyc(); cyc();
    Reset = 0;
    for (int c = 0; c < 5; c++) begin
      cyc(); #1;
      if (cp0_redirect) redir_cnt++;
      if (c == 0) chk("rst_release_run", 32'(outs), 32'(O_RUN));
    end
    chk("rst_no_redirect", 32'(redir_cnt), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
- Central stall/bubble scheduler for the 5-stage pipeline.
- Drives the IF/ID register's hazard, BranchBubble and cp0Bubble controls, plus PC write-enable and the ID/EX flush.
- Detects load-use and branch-operand hazards each cycle.
- Sequences two multi-cycle events: the mult/div busy window and the SYSCALL/ERET drain before the PC redirect.

Parameters:
- MD_CYCLES, 32: cycles the mult/div unit stays busy after md_start (legal 2..63).
- DRAIN_CYCLES, 3: cycles cp0Bubble is held for SYSCALL/ERET before the redirect (legal 1..7).

Ports:
- Clk  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-high reset.
- id_rs  input  5  ID-stage rs field.
- id_rt  input  5  ID-stage rt field.
- id_use_rs  input  1  ID instruction reads rs.
- id_use_rt  input  1  ID instruction reads rt.
- id_is_branch  input  1  ID instruction is a branch resolved in ID (beq/bne etc.).
- id_hilo_rd  input  1  ID instruction reads HI/LO (mfhi/mflo).
- id_cp0Op  input  3  ID cp0 operation; SYSCALL=3'b100, ERET=3'b011.
- ex_MemRead  input  1  EX instruction is a load.
- ex_RegWrite  input  1  EX instruction writes the GPR file.
- ex_rd  input  5  EX destination register.
- mem_MemRead  input  1  MEM instruction is a load.
- mem_rd  input  5  MEM destination register.
- md_start  input  1  EX launches mult/div this cycle.
- hazard  output  1  freeze PC and IF/ID (load-use or HI/LO wait).
- BranchBubble  output  1  freeze IF/ID for a branch whose operand is not yet forwardable.
- cp0Bubble  output  1  freeze IF/ID during the cp0 drain.
- idex_flush  output  1  insert a NOP into ID/EX.
- pc_write  output  1  PC register enable.
- cp0_redirect  output  1  one-cycle pulse: PC loads the exception vector or EPC.
- md_busy  output  1  mult/div unit busy.

Behaviour:
- States: RUN, MD_BUSY, CP0_DRAIN. Registers: state, md_cnt (6 bits), dr_cnt (3 bits).
- Reset (async, active-high): state=RUN, md_cnt=0, dr_cnt=0. While Reset is high, all outputs are 0 except pc_write=0.
- Match helpers (register 0 never matches):
  - mex = ex_rd!=0 && ((id_use_rs && id_rs==ex_rd) || (id_use_rt && id_rt==ex_rd)).
  - mmem is the same test against mem_rd.
- Combinational conditions, evaluated in RUN and MD_BUSY:
  - load_use = ex_MemRead && mex.
  - br_haz = id_is_branch && ((ex_RegWrite && mex) || (mem_MemRead && mmem)).
  - hilo_haz = md_busy && id_hilo_rd.
- Priority, highest first:
  1. load_use or hilo_haz: hazard=1, pc_write=0, idex_flush=1.
  2. br_haz: BranchBubble=1, pc_write=0, idex_flush=1.
  3. Otherwise pc_write=1.
- A load-use case into a branch raises hazard only; BranchBubble follows on the next cycle if still required.
- The three IF/ID freeze outputs are mutually exclusive in every cycle.
- RUN → MD_BUSY: on md_start; md_cnt loads MD_CYCLES-1 at that edge. md_start is accepted in the same cycle as a stall.
- MD_BUSY:
  - md_busy=1.
  - md_cnt decrements each cycle; at md_cnt==0 the block returns to RUN on the next edge.
  - A new md_start while in MD_BUSY reloads md_cnt (restart).
  - Total md_busy high time is exactly MD_CYCLES cycles.
- RUN/MD_BUSY → CP0_DRAIN:
  - Trigger: id_cp0Op is SYSCALL or ERET and neither hazard nor BranchBubble is asserted this cycle.
  - dr_cnt loads DRAIN_CYCLES-1.
  - An in-flight mult/div keeps counting in the background and md_busy stays correct; md_cnt continues decrementing.
- CP0_DRAIN:
  - cp0Bubble=1, pc_write=0, idex_flush=1.
  - hazard and BranchBubble are forced to 0.
  - dr_cnt decrements each cycle.
  - When dr_cnt==0: cp0_redirect=1 and pc_write=1 for that cycle; next state is MD_BUSY if md_cnt!=0, else RUN.
- id_cp0Op arriving during CP0_DRAIN is ignored; no nesting.
- All other id_cp0Op encodings are ignored.
- Reset asserted mid-operation aborts any busy or drain window immediately. No cp0_redirect is issued.

Test Plan:
- Load-use: ex_MemRead=1, ex_rd=5, id_rs=5, id_use_rs=1 → exactly 1 cycle of hazard=1, pc_write=0, idex_flush=1; the next cycle, with ex_MemRead=0, gives pc_write=1.
- Register 0: ex_MemRead=1, ex_rd=0, id_rs=0 → no stall, pc_write=1. A branch with ex_RegWrite=1, ex_rd=8, id_rt=8 → BranchBubble=1 for 1 cycle, hazard=0.
- Mult/div: md_start pulse, MD_CYCLES=32 → md_busy high exactly 32 cycles. id_hilo_rd=1 on cycle 10 → hazard held until md_busy falls, then pc_write=1. A second md_start on cycle 5 extends busy to cycle 37.
- SYSCALL: id_cp0Op=3'b100, DRAIN_CYCLES=3 → cp0Bubble=1 for 3 cycles, cp0_redirect=1 only on the 3rd cycle, then RUN. ERET (3'b011) behaves identically. 3'b001 is ignored.
- Simultaneous events: SYSCALL plus load_use in the same cycle → hazard wins and no drain starts that cycle; the drain starts the following cycle. SYSCALL while md_busy → after the drain, the state returns to MD_BUSY with the correct remaining count.
- Asynchronous reset: assert Reset mid-CP0_DRAIN, between clock edges → outputs go to reset values immediately, cp0_redirect never pulses, state=RUN after release.
